// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel and IF/ID output bundle of the fetch stage.
// The master side is the fetch stage itself; the slave side is memory plus the decode boundary.
interface fetch_stage_if;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_id_valid;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_instr;

    modport master (
        output o_imem_req_valid,
        output o_imem_req_addr,
        output o_id_valid,
        output o_id_pc,
        output o_id_instr,
        input  i_imem_req_ready,
        input  i_imem_rsp_valid,
        input  i_imem_rsp_data
    );

    modport slave (
        input  o_imem_req_valid,
        input  o_imem_req_addr,
        input  o_id_valid,
        input  o_id_pc,
        input  o_id_instr,
        output i_imem_req_ready,
        output i_imem_rsp_valid,
        output i_imem_rsp_data
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, credit-limited in-order memory requests, instruction buffer feeding IF/ID,
// with hazard stall (hold output) and flush (redirect, discard younger work).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic [31:0]   i_redirect_pc,
    fetch_stage_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int AD = 2 * DEPTH;
    localparam int AW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] occupancy;
    logic [CW-1:0] drop_cnt;

    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [PW-1:0] buf_rd;
    logic [PW-1:0] buf_wr;

    // Stale requests still in flight after a flush need address slots too, hence twice DEPTH.
    logic [31:0]   af_addr [AD];
    logic [AW-1:0] af_rd;
    logic [AW-1:0] af_wr;
    logic [CW:0]   af_count;

    logic credit_ok;
    logic req_valid;
    logic accept;
    logic rsp;
    logic rsp_keep;
    logic rsp_drop;
    logic id_valid;
    logic push;
    logic pop;

    assign credit_ok = ({1'b0, outstanding} + {1'b0, occupancy}) < DEPTH_W;
    assign req_valid = !i_reset && !i_flush && credit_ok;
    assign accept    = req_valid && bus.i_imem_req_ready;
    assign rsp       = bus.i_imem_rsp_valid;
    assign rsp_drop  = rsp && (drop_cnt != '0);
    assign rsp_keep  = rsp && (drop_cnt == '0);
    assign id_valid  = (occupancy != '0);
    assign push      = rsp_keep && !i_flush;
    assign pop       = id_valid && !i_stall && !i_flush;

    assign bus.o_imem_req_valid = req_valid;
    assign bus.o_imem_req_addr  = pc;
    assign bus.o_id_valid       = id_valid;
    assign bus.o_id_pc          = buf_pc[buf_rd];
    assign bus.o_id_instr       = buf_instr[buf_rd];

    always_ff @(posedge i_clk) begin
        if (!i_reset && accept) begin
            af_addr[af_wr] <= pc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            occupancy   <= '0;
            drop_cnt    <= '0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            af_rd       <= '0;
            af_wr       <= '0;
            af_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= NOP;
            end
        end else begin
            if (accept) begin
                af_wr <= af_wr + 1'b1;
            end
            if (rsp) begin
                af_rd <= af_rd + 1'b1;
            end
            af_count <= af_count + (CW + 1)'(accept) - (CW + 1)'(rsp);

            if (i_flush) begin
                // Everything in flight becomes stale; a response landing now is already discarded.
                pc          <= i_redirect_pc;
                outstanding <= '0;
                drop_cnt    <= drop_cnt + outstanding - CW'(rsp);
                occupancy   <= '0;
                buf_rd      <= '0;
                buf_wr      <= '0;
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                outstanding <= outstanding + CW'(accept) - CW'(rsp_keep);
                drop_cnt    <= drop_cnt - CW'(rsp_drop);
                if (push) begin
                    buf_pc[buf_wr]    <= af_addr[af_rd];
                    buf_instr[buf_wr] <= bus.i_imem_rsp_data;
                    buf_wr            <= buf_wr + 1'b1;
                end
                if (pop) begin
                    buf_rd <= buf_rd + 1'b1;
                end
                occupancy <= occupancy + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (!(rsp && outstanding == '0 && drop_cnt == '0));
            assert (({1'b0, outstanding} + {1'b0, occupancy}) <= DEPTH_W);
            assert (af_count == ({1'b0, outstanding} + {1'b0, drop_cnt}));
            assert (!(push && !pop && {1'b0, occupancy} == DEPTH_W));
            assert ({1'b0, drop_cnt} <= DEPTH_W);
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: behavioural memory, expected-instruction scoreboard,
// plus a second instance started near the top of the address space to exercise PC wrap.
module tb_fetch_stage;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] redirect;

    int compared   = 0;
    int mismatched = 0;

    req_t        memq[$];
    exp_t        sbq[$];
    int          lat          = 1;
    bit          toggle_ready = 1'b0;
    int          edge_cnt     = 0;
    logic [31:0] exp_pc       = 32'h0;

    logic [31:0] wrap_pcs[$];
    logic [31:0] wrap_instrs[$];

    fetch_stage_if bus ();
    fetch_stage_if wbus ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect_pc (redirect),
        .bus           (bus)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (1'b0),
        .i_flush       (1'b0),
        .i_redirect_pc (32'h0),
        .bus           (wbus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail_timeout(input string tag);
        compared++;
        mismatched++;
        $error("[TB] FAIL %s: timed out waiting for DUT", tag);
    endtask

    task automatic wait_pc(input logic [31:0] target, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.o_id_valid === 1'b1 && bus.o_id_pc === target) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_timeout(tag);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_id_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_timeout(tag);
    endtask

    // Reference PC sequence and expected IF/ID stream, advanced at each edge from pre-edge values.
    always @(posedge clk) begin
        edge_cnt++;
        if (reset) begin
            memq.delete();
            sbq.delete();
            exp_pc = 32'h0;
        end else begin
            if (bus.o_id_valid && !stall && !flush && sbq.size() > 0) void'(sbq.pop_front());
            if (flush) begin
                sbq.delete();
                exp_pc = redirect;
            end
            if (bus.o_imem_req_valid) check_output("req_addr", bus.o_imem_req_addr, exp_pc);
            if (bus.o_imem_req_valid && bus.i_imem_req_ready) begin
                memq.push_back('{bus.o_imem_req_addr, edge_cnt + lat});
                sbq.push_back('{exp_pc, exp_pc ^ KEY});
                exp_pc = exp_pc + 32'd4;
            end
        end
    end

    // In-order memory: a response is presented in the cycle before its due edge.
    always @(negedge clk) begin
        bus.i_imem_req_ready = toggle_ready ? edge_cnt[0] : 1'b1;
        bus.i_imem_rsp_valid = 1'b0;
        bus.i_imem_rsp_data  = 32'h0;
        if (!reset && memq.size() > 0 && memq[0].due <= edge_cnt + 1) begin
            bus.i_imem_rsp_valid = 1'b1;
            bus.i_imem_rsp_data  = memq[0].addr ^ KEY;
            void'(memq.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!reset && bus.o_id_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                fail_timeout("id_unexpected");
            end else begin
                check_output("id_pc", bus.o_id_pc, sbq[0].pc);
                check_output("id_instr", bus.o_id_instr, sbq[0].instr);
            end
        end
    end

    // Wrap instance: always-ready memory with one-cycle echo, never stalled.
    assign wbus.i_imem_req_ready = 1'b1;

    always @(posedge clk) begin
        wbus.i_imem_rsp_valid <= !reset && wbus.o_imem_req_valid;
        wbus.i_imem_rsp_data  <= wbus.o_imem_req_addr ^ KEY;
    end

    always @(negedge clk) begin
        if (!reset && wbus.o_id_valid === 1'b1 && wrap_pcs.size() < 3) begin
            wrap_pcs.push_back(wbus.o_id_pc);
            wrap_instrs.push_back(wbus.o_id_instr);
        end
    end

    initial begin
        bit found;
        reset    = 1'b1;
        stall    = 1'b0;
        flush    = 1'b0;
        redirect = 32'h0;
        repeat (3) @(negedge clk);

        check_output("rst_id_valid", 32'(bus.o_id_valid), 32'h0);
        check_output("rst_id_pc", bus.o_id_pc, 32'h0);
        check_output("rst_id_instr", bus.o_id_instr, NOP);
        check_output("rst_req_valid", 32'(bus.o_imem_req_valid), 32'h0);
        check_output("rst_wrap_addr", wbus.o_imem_req_addr, 32'hFFFF_FFF8);

        reset = 1'b0;
        @(negedge clk);
        check_output("lat_cycle1_valid", 32'(bus.o_id_valid), 32'h0);
        @(negedge clk);
        check_output("lat_cycle2_valid", 32'(bus.o_id_valid), 32'h1);
        check_output("lat_cycle2_pc", bus.o_id_pc, 32'h0);

        // Stall while PC 8 is presented: output holds and credits run out.
        wait_pc(32'h8, 40, "wait_pc8");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_hold_pc", bus.o_id_pc, 32'h8);
            check_output("stall_hold_instr", bus.o_id_instr, 32'h8 ^ KEY);
        end
        check_output("stall_credit_full", 32'(bus.o_imem_req_valid), 32'h0);
        stall = 1'b0;
        wait_pc(32'h10, 40, "wait_pc16");

        // Flush with two requests in flight on a slow memory.
        lat   = 3;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (memq.size() == 2) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_timeout("wait_two_inflight");
        flush    = 1'b1;
        redirect = 32'h100;
        #1;
        check_output("flush_suppress_req", 32'(bus.o_imem_req_valid), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_output("flush_id_cleared", 32'(bus.o_id_valid), 32'h0);
        check_output("flush_first_req_valid", 32'(bus.o_imem_req_valid), 32'h1);
        check_output("flush_first_req_addr", bus.o_imem_req_addr, 32'h100);
        wait_valid(60, "wait_redirect_out");
        check_output("redirect_first_pc", bus.o_id_pc, 32'h100);

        // Flush and stall together while a response lands.
        lat = 1;
        repeat (12) @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (bus.i_imem_rsp_valid === 1'b1 && bus.o_id_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) fail_timeout("wait_rsp_and_valid");
        stall    = 1'b1;
        flush    = 1'b1;
        redirect = 32'h200;
        @(negedge clk);
        check_output("flush_stall_id_cleared", 32'(bus.o_id_valid), 32'h0);
        stall = 1'b0;
        flush = 1'b0;
        #1;
        check_output("flush_stall_req_addr", bus.o_imem_req_addr, 32'h200);
        wait_valid(40, "wait_flush_stall_out");
        check_output("flush_stall_first_pc", bus.o_id_pc, 32'h200);

        // Ready toggling: address must hold until accepted, stream stays gap-free.
        toggle_ready = 1'b1;
        wait_pc(32'h220, 200, "wait_toggle_stream");
        toggle_ready = 1'b0;
        repeat (4) @(negedge clk);

        if (wrap_pcs.size() < 3) begin
            fail_timeout("wrap_collect");
        end else begin
            check_output("wrap_pc0", wrap_pcs[0], 32'hFFFF_FFF8);
            check_output("wrap_pc1", wrap_pcs[1], 32'hFFFF_FFFC);
            check_output("wrap_pc2", wrap_pcs[2], 32'h0000_0000);
            check_output("wrap_instr2", wrap_instrs[2], KEY);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
